// File: rtl/bram_phase_arbiter.sv
// bram_phase_arbiter
//   Owns the single port of the read-first puzzle BRAM and hands it to one client per board
//   phase: parser writes in LOAD, solver reads/writes in SOLVE, tx readback reads in DUMP.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i                       begin a new board (IDLE only)
//   p_valid_i/p_addr_i/p_data_i   parser write request, p_ready_o accepts; p_done_i ends LOAD
//   s_valid_i/s_we_i/s_addr_i/s_data_i  solver request, s_ready_o accepts
//   s_rvalid_o/s_rdata_o          solver read return; s_done_i ends SOLVE
//   t_valid_i/t_addr_i            readback read request, t_ready_o accepts
//   t_rvalid_o/t_rdata_o          readback read return; t_done_i ends DUMP
//   addra_o/dina_o/wea_o/ena_o/regcea_o, douta_i   BRAM port
//   phase_o                       0 IDLE, 1 LOAD, 2 SOLVE, 3 DUMP
module bram_phase_arbiter #(
    parameter int unsigned AddrWidth   = 16,
    parameter int unsigned DataWidth   = 13,
    parameter int unsigned ReadLatency = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 p_valid_i,
    input  logic [AddrWidth-1:0] p_addr_i,
    input  logic [DataWidth-1:0] p_data_i,
    output logic                 p_ready_o,
    input  logic                 p_done_i,
    input  logic                 s_valid_i,
    input  logic                 s_we_i,
    input  logic [AddrWidth-1:0] s_addr_i,
    input  logic [DataWidth-1:0] s_data_i,
    output logic                 s_ready_o,
    output logic                 s_rvalid_o,
    output logic [DataWidth-1:0] s_rdata_o,
    input  logic                 s_done_i,
    input  logic                 t_valid_i,
    input  logic [AddrWidth-1:0] t_addr_i,
    output logic                 t_ready_o,
    output logic                 t_rvalid_o,
    output logic [DataWidth-1:0] t_rdata_o,
    input  logic                 t_done_i,
    output logic [AddrWidth-1:0] addra_o,
    output logic [DataWidth-1:0] dina_o,
    output logic                 wea_o,
    output logic                 ena_o,
    output logic                 regcea_o,
    input  logic [DataWidth-1:0] douta_i,
    output logic [1:0]           phase_o
);

    // One stage for the issue register plus the BRAM's own read latency.
    localparam int unsigned PipeDepth = ReadLatency + 1;

    localparam logic [1:0] OwnNone   = 2'd0;
    localparam logic [1:0] OwnSolver = 2'd1;
    localparam logic [1:0] OwnTx     = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StSolve = 2'd2,
        StDump  = 2'd3
    } phase_e;

    // Reset asserts asynchronously, releases synchronously.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    phase_e                         phase_q;
    logic                           s_done_q;
    logic                           t_done_q;
    logic [PipeDepth-1:0][1:0]      tag_q;
    logic [AddrWidth-1:0]           addra_q;
    logic [DataWidth-1:0]           dina_q;
    logic                           wea_q;
    logic                           ena_q;
    logic                           s_rvalid_q;
    logic                           t_rvalid_q;
    logic [DataWidth-1:0]           s_rdata_q;
    logic [DataWidth-1:0]           t_rdata_q;

    logic                 pipe_empty;
    logic                 s_done_seen;
    logic                 t_done_seen;
    logic                 p_acc;
    logic                 s_acc;
    logic                 t_acc;
    logic                 acc_any;
    logic                 issue_we;
    logic [AddrWidth-1:0] issue_addr;
    logic [DataWidth-1:0] issue_data;
    logic [1:0]           tag_in;

    assign pipe_empty  = (tag_q == '0);
    assign s_done_seen = s_done_q | s_done_i;
    assign t_done_seen = t_done_q | t_done_i;

    // Grant drops in the cycle a done arrives and stays low while reads drain.
    assign p_ready_o = (phase_q == StLoad)  & ~p_done_i;
    assign s_ready_o = (phase_q == StSolve) & ~s_done_seen;
    assign t_ready_o = (phase_q == StDump)  & ~t_done_seen;

    assign p_acc   = p_valid_i & p_ready_o;
    assign s_acc   = s_valid_i & s_ready_o;
    assign t_acc   = t_valid_i & t_ready_o;
    assign acc_any = p_acc | s_acc | t_acc;

    always_comb begin
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        tag_in     = OwnNone;
        if (p_acc) begin
            issue_we   = 1'b1;
            issue_addr = p_addr_i;
            issue_data = p_data_i;
        end else if (s_acc) begin
            issue_we   = s_we_i;
            issue_addr = s_addr_i;
            issue_data = s_data_i;
            tag_in     = s_we_i ? OwnNone : OwnSolver;
        end else if (t_acc) begin
            issue_addr = t_addr_i;
            tag_in     = OwnTx;
        end
    end

    // Phase FSM with latched done flags; a done only counts in its own phase.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            phase_q  <= StIdle;
            s_done_q <= 1'b0;
            t_done_q <= 1'b0;
        end else begin
            unique case (phase_q)
                StIdle: begin
                    if (start_i) phase_q <= StLoad;
                end
                StLoad: begin
                    if (p_done_i) phase_q <= StSolve;
                end
                StSolve: begin
                    if (s_done_seen && pipe_empty) begin
                        phase_q  <= StDump;
                        s_done_q <= 1'b0;
                    end else if (s_done_i) begin
                        s_done_q <= 1'b1;
                    end
                end
                StDump: begin
                    if (t_done_seen && pipe_empty) begin
                        phase_q  <= StIdle;
                        t_done_q <= 1'b0;
                    end else if (t_done_i) begin
                        t_done_q <= 1'b1;
                    end
                end
                default: phase_q <= StIdle;
            endcase
        end
    end

    // Issue register and owner-tagged read return pipe. douta is valid while the tag sits
    // in the last stage, so it is captured on the edge that shifts the tag out.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            addra_q    <= '0;
            dina_q     <= '0;
            wea_q      <= 1'b0;
            ena_q      <= 1'b0;
            tag_q      <= '0;
            s_rvalid_q <= 1'b0;
            t_rvalid_q <= 1'b0;
            s_rdata_q  <= '0;
            t_rdata_q  <= '0;
        end else begin
            ena_q <= acc_any;
            wea_q <= acc_any & issue_we;
            if (acc_any) begin
                addra_q <= issue_addr;
                dina_q  <= issue_data;
            end
            tag_q      <= {tag_q[PipeDepth-2:0], tag_in};
            s_rvalid_q <= (tag_q[PipeDepth-1] == OwnSolver);
            t_rvalid_q <= (tag_q[PipeDepth-1] == OwnTx);
            if (tag_q[PipeDepth-1] == OwnSolver) s_rdata_q <= douta_i;
            if (tag_q[PipeDepth-1] == OwnTx)     t_rdata_q <= douta_i;
        end
    end

    assign addra_o    = addra_q;
    assign dina_o     = dina_q;
    assign wea_o      = wea_q;
    assign ena_o      = ena_q;
    assign regcea_o   = rst_int_n;
    assign s_rvalid_o = s_rvalid_q;
    assign s_rdata_o  = s_rdata_q;
    assign t_rvalid_o = t_rvalid_q;
    assign t_rdata_o  = t_rdata_q;
    assign phase_o    = phase_q;

endmodule
